// File: rtl/branch_flag_unit.sv
// Flag register, program counter and Start/Halt/Done sequencing for the basic processor.
// Branches resolve against the registered flags; a same-cycle flag write is seen only by the next branch.
module branch_flag_unit #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             START,
    input  logic [PC_W-1:0]  START_ADDR,
    input  logic             HALT,
    input  logic             FLAG_WE,
    input  logic             SC_IN,
    input  logic             ZERO_IN,
    input  logic             GREATER_IN,
    input  logic [2:0]       BR_COND,
    input  logic             ABS_JUMP,
    input  logic [PC_W-1:0]  TARGET,
    output logic [PC_W-1:0]  PC,
    output logic             SC_Q,
    output logic             ZERO_Q,
    output logic             GREATER_Q,
    output logic             TAKEN,
    output logic             DONE,
    output logic [CNT_W-1:0] CYCLES
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               sc_q, sc_d;
    logic               zero_q, zero_d;
    logic               greater_q, greater_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;
    logic               cond_met;
    logic               taken;

    always_comb begin
        cond_met = 1'b0;
        case (BR_COND)
            3'b001:  cond_met = 1'b1;
            3'b010:  cond_met = zero_q;
            3'b011:  cond_met = !zero_q;
            3'b100:  cond_met = greater_q;
            3'b101:  cond_met = !greater_q;
            3'b110:  cond_met = sc_q;
            default: cond_met = 1'b0;
        endcase
    end

    // START and HALT both pre-empt the branch, so neither may report it taken.
    assign taken = (state_q == S_RUN) && !START && !HALT && cond_met;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sc_d      = sc_q;
        zero_d    = zero_q;
        greater_d = greater_q;
        done_d    = done_q;
        cycles_d  = cycles_q;
        if (START) begin
            state_d   = S_RUN;
            pc_d      = START_ADDR;
            sc_d      = 1'b0;
            zero_d    = 1'b0;
            greater_d = 1'b0;
            done_d    = 1'b0;
            cycles_d  = '0;
        end else if (state_q == S_RUN) begin
            if (cycles_q != {CNT_W{1'b1}}) begin
                cycles_d = cycles_q + 1'b1;
            end
            if (FLAG_WE) begin
                sc_d      = SC_IN;
                zero_d    = ZERO_IN;
                greater_d = GREATER_IN;
            end
            if (HALT) begin
                state_d = S_HALTED;
                done_d  = 1'b1;
            end else if (taken) begin
                // Relative targets are two's complement; PC_W-bit addition wraps naturally.
                pc_d = ABS_JUMP ? TARGET : pc_q + TARGET;
            end else begin
                pc_d = pc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            sc_q      <= 1'b0;
            zero_q    <= 1'b0;
            greater_q <= 1'b0;
            done_q    <= 1'b0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            sc_q      <= sc_d;
            zero_q    <= zero_d;
            greater_q <= greater_d;
            done_q    <= done_d;
            cycles_q  <= cycles_d;
        end
    end

    assign PC        = pc_q;
    assign SC_Q      = sc_q;
    assign ZERO_Q    = zero_q;
    assign GREATER_Q = greater_q;
    assign TAKEN     = taken;
    assign DONE      = done_q;
    assign CYCLES    = cycles_q;

endmodule

// File: tb/tb_branch_flag_unit.sv
// Scoreboard bench for branch_flag_unit: a behavioural model pushes expected post-edge state,
// a monitor pops and compares one cycle later; TAKEN is checked combinationally before the edge.
module tb_branch_flag_unit;

    localparam int PC_W  = 10;
    localparam int CNT_W = 4;   // narrow counter so saturation is reachable quickly

    logic             CLK = 1'b0;
    logic             Reset, START, HALT, FLAG_WE, SC_IN, ZERO_IN, GREATER_IN, ABS_JUMP;
    logic [PC_W-1:0]  START_ADDR, TARGET;
    logic [2:0]       BR_COND;
    logic [PC_W-1:0]  PC;
    logic             SC_Q, ZERO_Q, GREATER_Q, TAKEN, DONE;
    logic [CNT_W-1:0] CYCLES;

    branch_flag_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .Reset(Reset), .START(START), .START_ADDR(START_ADDR), .HALT(HALT),
        .FLAG_WE(FLAG_WE), .SC_IN(SC_IN), .ZERO_IN(ZERO_IN), .GREATER_IN(GREATER_IN),
        .BR_COND(BR_COND), .ABS_JUMP(ABS_JUMP), .TARGET(TARGET), .PC(PC), .SC_Q(SC_Q),
        .ZERO_Q(ZERO_Q), .GREATER_Q(GREATER_Q), .TAKEN(TAKEN), .DONE(DONE), .CYCLES(CYCLES)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [PC_W-1:0]  pc;
        logic             sc, z, g, done;
        logic [CNT_W-1:0] cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // model state: 0 idle, 1 run, 2 halted
    int               m_state = 0;
    logic [PC_W-1:0]  m_pc = '0;
    logic             m_sc = 1'b0, m_z = 1'b0, m_g = 1'b0, m_done = 1'b0;
    logic [CNT_W-1:0] m_cyc = '0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic model_cond(input logic [2:0] c);
        case (c)
            3'b001:  return 1'b1;
            3'b010:  return m_z;
            3'b011:  return !m_z;
            3'b100:  return m_g;
            3'b101:  return !m_g;
            3'b110:  return m_sc;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input logic rst, input logic st, input logic [PC_W-1:0] addr,
                         input logic halt, input logic fwe, input logic sc, input logic z,
                         input logic g, input logic [2:0] cond, input logic abs_j,
                         input logic [PC_W-1:0] tgt);
        logic m_taken;
        exp_t e;
        @(negedge CLK);
        Reset = rst; START = st; START_ADDR = addr; HALT = halt; FLAG_WE = fwe;
        SC_IN = sc; ZERO_IN = z; GREATER_IN = g; BR_COND = cond; ABS_JUMP = abs_j; TARGET = tgt;
        #1;
        m_taken = (m_state == 1) && !st && !halt && model_cond(cond);
        if (!rst) check_val("taken", {31'd0, TAKEN}, {31'd0, m_taken});
        if (rst) begin
            m_state = 0; m_pc = '0; m_sc = 0; m_z = 0; m_g = 0; m_done = 0; m_cyc = '0;
        end else if (st) begin
            m_state = 1; m_pc = addr; m_sc = 0; m_z = 0; m_g = 0; m_done = 0; m_cyc = '0;
        end else if (m_state == 1) begin
            if (m_cyc != {CNT_W{1'b1}}) m_cyc = m_cyc + 1'b1;
            if (halt) begin
                m_state = 2; m_done = 1'b1;
            end else if (m_taken) begin
                m_pc = abs_j ? tgt : PC_W'(int'(m_pc) + int'(signed'(tgt)));
            end else begin
                m_pc = m_pc + 1'b1;
            end
            if (fwe) begin m_sc = sc; m_z = z; m_g = g; end
        end
        e.pc = m_pc; e.sc = m_sc; e.z = m_z; e.g = m_g; e.done = m_done; e.cyc = m_cyc;
        exp_q.push_back(e);
        $display("txn rst=%0b st=%0b halt=%0b fwe=%0b cond=%0d abs=%0b tgt=%03h -> exp pc=%03h cyc=%0d done=%0b taken=%0b",
                 rst, st, halt, fwe, cond, abs_j, tgt, m_pc, m_cyc, m_done, m_taken);
    endtask

    // shorthand for an ordinary RUN/IDLE cycle
    task automatic run(input logic [2:0] cond, input logic abs_j, input logic [PC_W-1:0] tgt);
        drive(0, 0, '0, 0, 0, 0, 0, 0, cond, abs_j, tgt);
    endtask

    always @(posedge CLK) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_val("pc",      32'(PC),        32'(e.pc));
            check_val("sc_q",    32'(SC_Q),      32'(e.sc));
            check_val("zero_q",  32'(ZERO_Q),    32'(e.z));
            check_val("gt_q",    32'(GREATER_Q), 32'(e.g));
            check_val("done",    32'(DONE),      32'(e.done));
            check_val("cycles",  32'(CYCLES),    32'(e.cyc));
        end
    end

    initial begin
        Reset = 1; START = 0; START_ADDR = '0; HALT = 0; FLAG_WE = 0; SC_IN = 0; ZERO_IN = 0;
        GREATER_IN = 0; BR_COND = 3'b000; ABS_JUMP = 0; TARGET = '0;
        drive(1, 0, '0, 0, 0, 0, 0, 0, 3'b000, 0, '0);
        drive(1, 0, '0, 0, 0, 0, 0, 0, 3'b001, 0, '0);
        run(3'b001, 1, 10'h155);                        // IDLE holds, never taken
        // sequential fetch
        drive(0, 1, 10'h010, 0, 0, 0, 0, 0, 3'b000, 0, '0);
        repeat (3) run(3'b000, 0, '0);
        // same-cycle flag write is invisible to the branch
        drive(0, 1, 10'h020, 0, 0, 0, 0, 0, 3'b000, 0, '0);
        drive(0, 0, '0, 0, 1, 0, 1, 0, 3'b010, 1, 10'h100);
        run(3'b010, 1, 10'h100);
        // relative backward branch on GREATER
        drive(0, 1, 10'h004, 0, 0, 0, 0, 0, 3'b000, 0, '0);
        drive(0, 0, '0, 0, 1, 0, 0, 1, 3'b000, 0, '0);
        run(3'b100, 0, 10'h3FD);
        run(3'b101, 0, 10'h3FD);                        // !GREATER false -> fall through
        // PC wrap
        drive(0, 1, 10'h3FF, 0, 0, 0, 0, 0, 3'b000, 0, '0);
        run(3'b000, 0, '0);
        // HALT beats branch, flag write commits, then HALTED holds
        drive(0, 1, 10'h040, 0, 0, 0, 0, 0, 3'b000, 0, '0);
        drive(0, 0, '0, 1, 1, 1, 0, 0, 3'b001, 1, 10'h200);
        repeat (5) drive(0, 0, '0, 0, 1, 0, 1, 1, 3'b001, 1, 10'h2AA);
        // restart from HALTED
        drive(0, 1, 10'h080, 0, 0, 0, 0, 0, 3'b000, 0, '0);
        // counter saturation plus remaining conditions
        drive(0, 0, '0, 0, 1, 1, 0, 0, 3'b110, 0, 10'h005);
        run(3'b110, 0, 10'h005);
        run(3'b111, 1, 10'h000);
        run(3'b011, 0, 10'h002);
        repeat (16) run(3'b000, 0, '0);
        // randomized RUN traffic
        for (int i = 0; i < 40; i++) begin
            drive(0, ($urandom_range(0, 19) == 0), 10'($urandom), ($urandom_range(0, 24) == 0),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                  1'($urandom), 10'($urandom));
        end
        // reset mid-run with flags set
        drive(0, 1, 10'h0A3, 0, 0, 0, 0, 0, 3'b000, 0, '0);
        drive(0, 0, '0, 0, 1, 1, 1, 1, 3'b000, 0, '0);
        run(3'b000, 0, '0);
        drive(1, 0, '0, 0, 1, 1, 1, 1, 3'b000, 0, '0);
        run(3'b001, 1, 10'h0FF);
        run(3'b000, 0, '0);
        @(negedge CLK);
        @(negedge CLK);
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
